// File: rtl/oled_init_sequencer.sv
// -----------------------------------------------------------------------------
// oled_init_sequencer
//   Walks the SSD1306 initialisation command ROM and forwards each byte to the
//   downstream serial byte transmitter over a valid/ready handshake, flagged as
//   a command byte (tx_dc_o = 0). After a power-settle delay the sequencer
//   fetches ROM bytes one at a time (FETCH -> LOAD -> SEND) and raises done_o
//   once the panel is ready for frame data.
//
//   Optional feature macro: OLED_CLEAR_EN
//     Defined   : after the last command byte, CLEAR_BYTES bytes of 8'h00 are
//                 sent with tx_dc_o = 1 to blank the GRAM through the window
//                 set up by the ROM's final commands.
//     Undefined : no CLEAR state, no clear counter, tx_dc_o is constant 0.
// -----------------------------------------------------------------------------
module oled_init_sequencer #(
  parameter int NUM_CMDS      = 31,
  parameter int PWR_DELAY_CYC = 100000
`ifdef OLED_CLEAR_EN
  , parameter int CLEAR_BYTES = 1024
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  output logic [5:0] rom_addr_o,
  input  logic [7:0] rom_data_i,
  output logic       tx_valid_o,
  output logic [7:0] tx_byte_o,
  output logic       tx_dc_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       done_o
);

  // Delay counter only needs to reach PWR_DELAY_CYC-1.
  localparam int DLY_W = (PWR_DELAY_CYC > 1) ? $clog2(PWR_DELAY_CYC) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST =
    DLY_W'((PWR_DELAY_CYC > 0) ? PWR_DELAY_CYC - 1 : 0);
  localparam logic [5:0] ADDR_LAST = 6'(NUM_CMDS - 1);

`ifdef OLED_CLEAR_EN
  localparam logic [10:0] CLR_LAST = 11'(CLEAR_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PWR_WAIT = 3'd1,
    FETCH    = 3'd2,
    LOAD     = 3'd3,
    SEND     = 3'd4,
    CLEAR    = 3'd5,
    FIN      = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PWR_WAIT = 3'd1,
    FETCH    = 3'd2,
    LOAD     = 3'd3,
    SEND     = 3'd4,
    FIN      = 3'd6
  } state_e;
`endif

  state_e           state_q,    state_d;
  logic [DLY_W-1:0] dly_q,      dly_d;
  logic [5:0]       rom_addr_q, rom_addr_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_byte_q,  tx_byte_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
`ifdef OLED_CLEAR_EN
  logic [10:0]      clr_q,      clr_d;
  logic             tx_dc_q,    tx_dc_d;
`endif

  // Next-state and output-register logic for the sequencer FSM.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    dly_d      = dly_q;
    rom_addr_d = rom_addr_q;
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef OLED_CLEAR_EN
    clr_d      = clr_q;
    tx_dc_d    = tx_dc_q;
`endif

    unique case (state_q)
      IDLE: begin
        // start while busy cannot occur here: busy is only set outside IDLE.
        if (start_i) begin
          done_d     = 1'b0;
          busy_d     = 1'b1;
          dly_d      = '0;
          rom_addr_d = '0;
          state_d    = (PWR_DELAY_CYC == 0) ? FETCH : PWR_WAIT;
        end
      end

      PWR_WAIT: begin
        if (dly_q == DLY_LAST) begin
          rom_addr_d = '0;
          state_d    = FETCH;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      // The ROM registers rom_addr this cycle; its data is valid in LOAD.
      FETCH: state_d = LOAD;

      LOAD: begin
        tx_byte_d  = rom_data_i;
        tx_valid_d = 1'b1;
`ifdef OLED_CLEAR_EN
        tx_dc_d    = 1'b0;
`endif
        state_d    = SEND;
      end

      // Byte is held stable until the transmitter takes it.
      SEND: begin
        if (tx_valid_q && tx_ready_i) begin
          tx_valid_d = 1'b0;
          if (rom_addr_q == ADDR_LAST) begin
`ifdef OLED_CLEAR_EN
            clr_d   = '0;
            state_d = CLEAR;
`else
            state_d = FIN;
`endif
          end else begin
            rom_addr_d = rom_addr_q + 6'd1;
            state_d    = FETCH;
          end
        end
      end

`ifdef OLED_CLEAR_EN
      // Offer a zero data byte, wait for its transfer, repeat CLEAR_BYTES times.
      CLEAR: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_byte_d  = 8'h00;
          tx_dc_d    = 1'b1;
        end else if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          if (clr_q == CLR_LAST) begin
            state_d = FIN;
          end else begin
            clr_d = clr_q + 11'd1;
          end
        end
      end
`endif

      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      rom_addr_q <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef OLED_CLEAR_EN
      clr_q      <= '0;
      tx_dc_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle, independent of statement order.
      state_q    <= state_d;
      dly_q      <= dly_d;
      rom_addr_q <= rom_addr_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef OLED_CLEAR_EN
      clr_q      <= clr_d;
      tx_dc_q    <= tx_dc_d;
`endif
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_byte_o  = tx_byte_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
`ifdef OLED_CLEAR_EN
  assign tx_dc_o    = tx_dc_q;
`else
  assign tx_dc_o    = 1'b0;
`endif

endmodule

// File: tb/tb_oled_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_oled_init_sequencer
//   Drives oled_init_sequencer with a registered-read ROM model, captures every
//   transmitter transfer into a scoreboard and compares it with the byte list
//   derived from the ROM contents (plus the GRAM clear bytes when OLED_CLEAR_EN
//   is defined). Also checks reset values, first-byte latency, backpressure
//   holding, ignored start while busy, mid-run reset and done latency.
// -----------------------------------------------------------------------------
module tb_oled_init_sequencer;

  localparam int NUM_CMDS      = 31;
  localparam int PWR_DELAY_CYC = 10;
`ifdef OLED_CLEAR_EN
  localparam int CLEAR_BYTES   = 1024;
  localparam int RUNS          = 5;
`else
  localparam int RUNS          = 100;
`endif
  localparam int BUDGET        = 20000;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] rom_data;
  logic [5:0] rom_addr;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_dc;
  logic       busy;
  logic       done;

  oled_init_sequencer #(
    .NUM_CMDS      (NUM_CMDS),
    .PWR_DELAY_CYC (PWR_DELAY_CYC)
`ifdef OLED_CLEAR_EN
    , .CLEAR_BYTES (CLEAR_BYTES)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .tx_valid_o (tx_valid),
    .tx_byte_o  (tx_byte),
    .tx_dc_o    (tx_dc),
    .tx_ready_i (tx_ready),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // Init ROM: data appears the cycle after the address is presented.
  logic [7:0] rom_mem [64];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int xfer_edge = 0;

  logic [8:0] got   [$];   // {tx_dc, tx_byte} per observed transfer
  logic [8:0] exp_q [$];   // reference byte stream
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transfer capture and hold-while-stalled check, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'b0, tx_valid}, 32'd1);
        check("hold_word", {23'b0, tx_dc, tx_byte}, {23'b0, prev_word});
      end
      if (tx_valid && tx_ready) begin
        got.push_back({tx_dc, tx_byte});
        xfer_edge = cyc + 1;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_word  = {tx_dc, tx_byte};
    end
  end

  task automatic compare_sb(input string tag);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_b%0d", tag, i), {23'b0, got[i]}, {23'b0, exp_q[i]});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_done_clr", {31'b0, done}, 32'd0);
    check("start_busy", {31'b0, busy}, 32'd1);
  endtask

  // mode 0: ready high; 1: random ready; 2: stall 5 cycles on byte stall_idx.
  // start_idx >= 0 pulses start once while busy after that many transfers.
  task automatic run_to_done(input int mode, input int stall_idx, input int start_idx);
    int  stalls = 0;
    bit  sent   = 1'b0;
    bit  ok     = 1'b0;
    int  done_edge = -1;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        done_edge = cyc;
        ok = 1'b1;
        break;
      end
      if (start_idx >= 0 && !sent && got.size() == start_idx && busy) begin
        start = 1'b1;
        sent  = 1'b1;
      end
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: begin
          if (tx_valid && got.size() == stall_idx && stalls < 5) begin
            check("stall_byte", {24'b0, tx_byte}, {24'b0, exp_q[stall_idx][7:0]});
            stalls++;
            tx_ready = 1'b0;
          end else begin
            tx_ready = 1'b1;
          end
        end
      endcase
    end
    check("done_reached", {31'b0, ok}, 32'd1);
    if (ok) begin
      check("done_latency", done_edge, xfer_edge + 1);
      check("busy_after_done", {31'b0, busy}, 32'd0);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] init_bytes [NUM_CMDS];
    int n;
    init_bytes = '{8'hAE, 8'hD5, 8'hF0, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                   8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                   8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                   8'hAF, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
    for (int i = 0; i < 64; i++) rom_mem[i] = (i < NUM_CMDS) ? init_bytes[i] : 8'h00;

    // Reference stream: ROM commands in address order, then optional clear.
    for (int i = 0; i < NUM_CMDS; i++) exp_q.push_back({1'b0, init_bytes[i]});
`ifdef OLED_CLEAR_EN
    for (int i = 0; i < CLEAR_BYTES; i++) exp_q.push_back(9'h100);
`endif

    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_addr", {26'b0, rom_addr}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
    check("rst_tx_dc", {31'b0, tx_dc}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;

    // Ready tied high: first tx_valid 12 edges after the edge sampling start
    // (13 cycles counting the start cycle), then the full ordered stream.
    got.delete();
    tx_ready = 1'b1;
    pulse_start();
    n = 0;
    while (!tx_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_valid_lat", n, 12);
    run_to_done(0, -1, -1);
    compare_sb("basic");

    // Backpressure on byte 3 (8'hA8) for 5 cycles; restart from done.
    got.delete();
    pulse_start();
    run_to_done(2, 3, -1);
    compare_sb("bp");

    // start pulsed while busy at byte 10 must be ignored.
    got.delete();
    pulse_start();
    run_to_done(0, -1, 10);
    compare_sb("start_busy");

    // Reset while byte 20 waits in SEND, then full replay.
    got.delete();
    tx_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (got.size() >= 20) tx_ready = 1'b0;
      if (got.size() == 20 && tx_valid) break;
    end
    check("mid_byte20", {23'b0, tx_dc, tx_byte}, {23'b0, exp_q[20]});
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", {26'b0, rom_addr}, 32'd0);
    check("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
    check("mid_rst_byte", {24'b0, tx_byte}, 32'd0);
    check("mid_rst_dc", {31'b0, tx_dc}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got.delete();
    tx_ready = 1'b1;
    pulse_start();
    run_to_done(0, -1, -1);
    compare_sb("post_rst");

    // Random 50% ready over many runs.
    for (int r = 0; r < RUNS; r++) begin
      got.delete();
      pulse_start();
      run_to_done(1, -1, -1);
      compare_sb($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
